// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and default sizing for the multi-port SDRAM
// arbiter, plus the round-robin pointer advance helper.
package sdram_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_NUM_PORTS_DEF   = 4;
  localparam int ARB_ADDR_W_DEF      = 24;
  localparam int ARB_DATA_W_DEF      = 16;
  localparam int ARB_WAIT_CYCLES_DEF = 2;
  // Wait counter covers the full 0..7 WAIT_CYCLES range.
  localparam int ARB_CNT_W           = 3;

  // Index after idx (mod n), stepping over the priority port so the
  // round-robin pointer never rests on it.
  function automatic int arb_next_idx(input int idx, input int n, input int skip);
    int nxt;
    nxt = (idx + 1) % n;
    if (nxt == skip) nxt = (nxt + 1) % n;
    return nxt;
  endfunction

endpackage

// File: rtl/sdram_mport_arbiter_if.sv
// sdram_mport_arbiter_if: downstream command/response bus between the
// arbiter (master) and the SDRAM controller (slave).
interface sdram_mport_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W_DEF,
  parameter int DATA_W = ARB_DATA_W_DEF
);
  localparam int MASK_W = DATA_W / 8;

  logic              sdram_cmd_valid;
  logic              sdram_rd;
  logic              sdram_wr;
  logic              sdram_burst;
  logic              sdram_ack;
  logic [ADDR_W-1:0] sdram_addr_x16;
  logic [DATA_W-1:0] sdram_wdata;
  logic [MASK_W-1:0] sdram_wmask;
  logic              sdram_cmd_ready;
  logic              sdram_rdy;
  logic              sdram_resp_valid;
  logic              sdram_resp_last;
  logic [DATA_W-1:0] sdram_rdata;

  modport master (
    output sdram_cmd_valid, sdram_rd, sdram_wr, sdram_burst, sdram_ack,
           sdram_addr_x16, sdram_wdata, sdram_wmask,
    input  sdram_cmd_ready, sdram_rdy, sdram_resp_valid, sdram_resp_last,
           sdram_rdata
  );

  modport slave (
    input  sdram_cmd_valid, sdram_rd, sdram_wr, sdram_burst, sdram_ack,
           sdram_addr_x16, sdram_wdata, sdram_wmask,
    output sdram_cmd_ready, sdram_rdy, sdram_resp_valid, sdram_resp_last,
           sdram_rdata
  );

endinterface

// File: rtl/sdram_arb_rr_picker.sv
// sdram_arb_rr_picker: picks the first requesting port at or after ptr_i,
// wrapping around; returns a one-hot grant and its index.
module sdram_arb_rr_picker #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic found;
  int   cand;

  // Circular scan from the pointer; first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (int'(ptr_i) + k) % NUM_PORTS;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sdram_mport_arbiter.sv
// sdram_mport_arbiter: multi-port SDRAM command arbiter. PRIO_PORT (video)
// always wins; other ports are picked lowest-index first, or round-robin when
// SDRAM_ARB_ROUND_ROBIN_EN is defined. One transaction is owned at a time and
// released by the owner's port_ack.
//
// state    | meaning
// ARB_IDLE | no owner; winner's command presented downstream, grant on accept
// ARB_BUSY | owner's transaction in flight; ends on the owner's port_ack
module sdram_mport_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS   = ARB_NUM_PORTS_DEF,
  parameter int ADDR_W      = ARB_ADDR_W_DEF,
  parameter int DATA_W      = ARB_DATA_W_DEF,
  parameter int WAIT_CYCLES = ARB_WAIT_CYCLES_DEF,
  parameter int PRIO_PORT   = 0,
  localparam int IDX_W      = $clog2(NUM_PORTS),
  localparam int MASK_W     = DATA_W / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_PORTS-1:0]        port_cmd_valid,
  input  logic [NUM_PORTS-1:0]        port_rd,
  input  logic [NUM_PORTS-1:0]        port_wr,
  input  logic [NUM_PORTS-1:0]        port_burst,
  input  logic [NUM_PORTS-1:0]        port_ack,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr_x16,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
  input  logic [NUM_PORTS*MASK_W-1:0] port_wmask,
  output logic [NUM_PORTS-1:0]        port_cmd_ready,
  output logic [NUM_PORTS-1:0]        port_rdy,
  output logic [NUM_PORTS-1:0]        port_resp_valid,
  output logic [NUM_PORTS-1:0]        port_resp_last,
  output logic [DATA_W-1:0]           port_rdata,
  sdram_mport_arbiter_if.master       sdram,
  output logic [IDX_W-1:0]            owner_o,
  output logic                        busy_o
);

  localparam logic [IDX_W-1:0]     PRIO_IDX = IDX_W'(PRIO_PORT);
  localparam logic [ARB_CNT_W-1:0] WAIT_LD  = ARB_CNT_W'(WAIT_CYCLES);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  logic [NUM_PORTS-1:0] req_np;
  logic                 prio_req;
  logic [IDX_W-1:0]     np_idx;
  logic                 np_found;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic                 idle_live;
  logic                 busy_live;
  logic                 accept;
  logic [IDX_W-1:0]     sel_idx;

  logic [ADDR_W-1:0] addr_a  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_a [NUM_PORTS];
  logic [MASK_W-1:0] wmask_a [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_a[g]  = port_addr_x16[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = port_wdata[g*DATA_W +: DATA_W];
    assign wmask_a[g] = port_wmask[g*MASK_W +: MASK_W];
  end

  assign prio_req = port_cmd_valid[PRIO_PORT];

  // Requests competing below the priority port.
  always_comb begin
    req_np            = port_cmd_valid;
    req_np[PRIO_PORT] = 1'b0;
  end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  localparam logic [IDX_W-1:0] RR_RST = IDX_W'((PRIO_PORT == 0) ? 1 : 0);

  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] np_gnt;

  sdram_arb_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_picker (
    .req_i (req_np),
    .ptr_i (rr_ptr_q),
    .gnt_o (np_gnt),
    .idx_o (np_idx)
  );

  assign np_found = |np_gnt;

  // Pointer moves past a non-priority winner only when it is actually granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && !prio_req)
      rr_ptr_d = IDX_W'(arb_next_idx(int'(win_idx), NUM_PORTS, PRIO_PORT));
  end
`else
  // Fixed selection: lowest-index non-priority requester.
  always_comb begin
    np_idx   = '0;
    np_found = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_np[i]) begin
        np_idx   = IDX_W'(i);
        np_found = 1'b1;
      end
    end
  end
`endif

  assign win_found = prio_req | np_found;
  assign win_idx   = prio_req ? PRIO_IDX : np_idx;
  assign idle_live = rst_ni && (state_q == ARB_IDLE);
  assign busy_live = rst_ni && (state_q == ARB_BUSY);
  assign accept    = idle_live && win_found && sdram.sdram_cmd_ready;
  assign sel_idx   = idle_live ? win_idx : owner_q;

  // Next-state: grant on accept, release on the owner's ack only.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    if (state_q == ARB_IDLE) begin
      if (accept) begin
        state_d = ARB_BUSY;
        owner_d = win_idx;
        cnt_d   = WAIT_LD;
      end
    end else if (port_ack[owner_q]) begin
      state_d = ARB_IDLE;
    end
    busy_d = (state_d == ARB_BUSY);
  end

  // FSM and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= RR_RST;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign owner_o = owner_q;
  assign busy_o  = busy_q;

  // Downstream muxing and per-port handshakes. In IDLE the fields follow the
  // current winner so the controller sees a full command with cmd_valid;
  // with no winner (or in reset) everything is driven to zero.
  always_comb begin
    port_cmd_ready         = '0;
    port_rdy               = '0;
    port_resp_valid        = '0;
    port_resp_last         = '0;
    sdram.sdram_cmd_valid  = 1'b0;
    sdram.sdram_rd         = 1'b0;
    sdram.sdram_wr         = 1'b0;
    sdram.sdram_burst      = 1'b0;
    sdram.sdram_ack        = 1'b0;
    sdram.sdram_addr_x16   = '0;
    sdram.sdram_wdata      = '0;
    sdram.sdram_wmask      = '0;
    if (idle_live) sdram.sdram_cmd_valid = |port_cmd_valid;
    if ((idle_live && win_found) || busy_live) begin
      sdram.sdram_rd       = port_rd[sel_idx];
      sdram.sdram_wr       = port_wr[sel_idx];
      sdram.sdram_burst    = port_burst[sel_idx];
      sdram.sdram_addr_x16 = addr_a[sel_idx];
      sdram.sdram_wdata    = wdata_a[sel_idx];
      sdram.sdram_wmask    = wmask_a[sel_idx];
    end
    if (idle_live && win_found) port_cmd_ready[win_idx] = sdram.sdram_cmd_ready;
    if (busy_live) begin
      sdram.sdram_ack          = port_ack[owner_q];
      port_rdy[owner_q]        = (cnt_q == '0) && sdram.sdram_rdy;
      port_resp_valid[owner_q] = sdram.sdram_resp_valid;
      port_resp_last[owner_q]  = sdram.sdram_resp_last;
    end
  end

  assign port_rdata = sdram.sdram_rdata;

endmodule

// File: tb/tb_sdram_mport_arbiter.sv
// tb_sdram_mport_arbiter: directed bench for sdram_mport_arbiter. Expected
// grant indices are queued when requests are driven and popped when a grant
// is seen. Follows SDRAM_ARB_ROUND_ROBIN_EN for the round-robin expectations.
module tb_sdram_mport_arbiter;
  import sdram_arb_pkg::*;

  localparam int NP   = 4;
  localparam int AW   = 24;
  localparam int DW   = 16;
  localparam int MW   = DW / 8;
  localparam int WAIT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    port_cmd_valid, port_rd, port_wr, port_burst, port_ack;
  logic [NP*AW-1:0] port_addr_x16;
  logic [NP*DW-1:0] port_wdata;
  logic [NP*MW-1:0] port_wmask;
  logic [NP-1:0]    port_cmd_ready, port_rdy, port_resp_valid, port_resp_last;
  logic [DW-1:0]    port_rdata;
  logic [1:0]       owner;
  logic             busy;

  sdram_mport_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) sd_if ();

  sdram_mport_arbiter #(
    .NUM_PORTS   (NP),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WAIT_CYCLES (WAIT),
    .PRIO_PORT   (0)
  ) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .port_cmd_valid  (port_cmd_valid),
    .port_rd         (port_rd),
    .port_wr         (port_wr),
    .port_burst      (port_burst),
    .port_ack        (port_ack),
    .port_addr_x16   (port_addr_x16),
    .port_wdata      (port_wdata),
    .port_wmask      (port_wmask),
    .port_cmd_ready  (port_cmd_ready),
    .port_rdy        (port_rdy),
    .port_resp_valid (port_resp_valid),
    .port_resp_last  (port_resp_last),
    .port_rdata      (port_rdata),
    .sdram           (sd_if.master),
    .owner_o         (owner),
    .busy_o          (busy)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int onehot_idx(input logic [NP-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NP; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Waits up to max_cyc cycles for a grant, compares it with the scoreboard
  // head and leaves the bench in the first owned cycle.
  task automatic wait_grant(input int max_cyc, input string tag);
    bit got;
    int exp_idx;
    got = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      #1;
      if ((port_cmd_ready & port_cmd_valid) != '0) begin
        got     = 1'b1;
        exp_idx = -1;
        if (sb_q.size() > 0) exp_idx = sb_q.pop_front();
        chk(tag, 64'(onehot_idx(port_cmd_ready)), 64'(exp_idx));
        step();
        break;
      end
      step();
    end
    chk({tag, "_seen"}, 64'(got), 64'd1);
  endtask

  int n;
  int rr_exp [6];

  initial begin
    port_cmd_valid = '1;
    port_rd        = '1;
    port_wr        = '0;
    port_burst     = '0;
    port_ack       = '1;
    port_addr_x16  = '0;
    port_wdata     = '0;
    port_wmask     = '0;
    sd_if.sdram_cmd_ready  = 1'b1;
    sd_if.sdram_rdy        = 1'b1;
    sd_if.sdram_resp_valid = 1'b1;
    sd_if.sdram_resp_last  = 1'b0;
    sd_if.sdram_rdata      = '0;

    // Reset with every input active: all outputs must stay quiet.
    repeat (2) step();
    #1;
    chk("rst_cmd_ready", 64'(port_cmd_ready), 64'd0);
    chk("rst_sdram_cmd_valid", 64'(sd_if.sdram_cmd_valid), 64'd0);
    chk("rst_sdram_rd", 64'(sd_if.sdram_rd), 64'd0);
    chk("rst_sdram_ack", 64'(sd_if.sdram_ack), 64'd0);
    chk("rst_port_resp_valid", 64'(port_resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    port_cmd_valid = '0;
    port_rd        = '0;
    port_ack       = '0;
    sd_if.sdram_resp_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Single write from port 1.
    port_cmd_valid[1]     = 1'b1;
    port_wr[1]            = 1'b1;
    port_addr_x16[AW+:AW] = 24'h000100;
    port_wdata[DW+:DW]    = 16'hBEEF;
    port_wmask[MW+:MW]    = 2'b11;
    #1;
    chk("t1_ready_same_cycle", 64'(port_cmd_ready), 64'b0010);
    chk("t1_sdram_cmd_valid", 64'(sd_if.sdram_cmd_valid), 64'd1);
    chk("t1_sdram_addr", 64'(sd_if.sdram_addr_x16), 64'h000100);
    chk("t1_sdram_wdata", 64'(sd_if.sdram_wdata), 64'hBEEF);
    chk("t1_sdram_wr", 64'(sd_if.sdram_wr), 64'd1);
    sb_q.push_back(1);
    wait_grant(1, "t1_grant");
    port_cmd_valid = '0;
    #1;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_owner", 64'(owner), 64'd1);
    chk("t1_cmd_valid_low_in_busy", 64'(sd_if.sdram_cmd_valid), 64'd0);
    chk("t1_busy_addr", 64'(sd_if.sdram_addr_x16), 64'h000100);
    n = 0;
    while (port_rdy[1] !== 1'b1 && n < 20) begin
      n++;
      step();
      #1;
    end
    chk("t1_rdy_wait", 64'(n), 64'(WAIT));
    port_ack[1] = 1'b1;
    #1;
    chk("t1_sdram_ack", 64'(sd_if.sdram_ack), 64'd1);
    step();
    port_ack = '0;
    #1;
    chk("t1_back_idle", 64'(busy), 64'd0);
    port_wr = '0;
    step();

    // Priority port beats port 2; port 2 follows right after ack0.
    port_cmd_valid = 4'b0101;
    #1;
    chk("t2_ready_prio_only", 64'(port_cmd_ready), 64'b0001);
    sb_q.push_back(0);
    wait_grant(1, "t2_grant_prio");
    port_cmd_valid = 4'b0100;
    #1;
    chk("t2_no_ready_busy", 64'(port_cmd_ready), 64'd0);
    port_ack[0] = 1'b1;
    #1;
    chk("t2_no_grant_on_ack", 64'(port_cmd_ready), 64'd0);
    step();
    port_ack = '0;
    sb_q.push_back(2);
    wait_grant(1, "t2_grant_next");

    // Owner 2: responses only reach port 2, foreign ack is ignored.
    port_cmd_valid = '0;
    sd_if.sdram_resp_valid = 1'b1;
    sd_if.sdram_resp_last  = 1'b1;
    sd_if.sdram_rdata      = 16'h1234;
    port_ack = 4'b0010;
    #1;
    chk("t3_resp_valid", 64'(port_resp_valid), 64'b0100);
    chk("t3_resp_last", 64'(port_resp_last), 64'b0100);
    chk("t3_sdram_ack_low", 64'(sd_if.sdram_ack), 64'd0);
    chk("t3_rdata", 64'(port_rdata), 64'h1234);
    step();
    sd_if.sdram_resp_valid = 1'b0;
    sd_if.sdram_resp_last  = 1'b0;
    port_ack = '0;
    #1;
    chk("t3_still_busy", 64'(busy), 64'd1);
    chk("t3_owner", 64'(owner), 64'd2);
    port_ack = 4'b0100;
    step();
    port_ack = '0;
    #1;
    chk("t3_idle", 64'(busy), 64'd0);

    // Back-pressure from the controller.
    sd_if.sdram_cmd_ready = 1'b0;
    port_cmd_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_bp_ready", 64'(port_cmd_ready), 64'd0);
      chk("t4_bp_busy", 64'(busy), 64'd0);
      step();
    end
    #1;
    chk("t4_bp_cmd_valid", 64'(sd_if.sdram_cmd_valid), 64'd1);
    sd_if.sdram_cmd_ready = 1'b1;
    #1;
    chk("t4_ready3", 64'(port_cmd_ready), 64'b1000);
    sb_q.push_back(3);
    wait_grant(1, "t4_grant");
    port_cmd_valid = '0;
    port_ack = 4'b1000;
    step();
    port_ack = '0;
    #1;
    chk("t4_idle", 64'(busy), 64'd0);

    // Withdrawn request is not latched; idle bus is all zero.
    sd_if.sdram_cmd_ready = 1'b0;
    port_cmd_valid = 4'b0010;
    port_rd = '1;
    step();
    port_cmd_valid = '0;
    sd_if.sdram_cmd_ready = 1'b1;
    #1;
    chk("t5_no_ready", 64'(port_cmd_ready), 64'd0);
    chk("t5_addr_zero", 64'(sd_if.sdram_addr_x16), 64'd0);
    chk("t5_rd_zero", 64'(sd_if.sdram_rd), 64'd0);
    step();
    #1;
    chk("t5_stay_idle", 64'(busy), 64'd0);
    port_rd = '0;

    // Reset in the middle of an owned transaction.
    port_cmd_valid = 4'b0001;
    sb_q.push_back(0);
    wait_grant(2, "t6_grant");
    step();
    #1;
    chk("t6_cnt_before_rst", 64'(u_dut.cnt_q), 64'd2);
    sd_if.sdram_resp_valid = 1'b1;
    sd_if.sdram_resp_last  = 1'b1;
    port_ack = 4'b0001;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_rdy", 64'(port_rdy), 64'd0);
    chk("t6_rst_resp_valid", 64'(port_resp_valid), 64'd0);
    chk("t6_rst_resp_last", 64'(port_resp_last), 64'd0);
    chk("t6_rst_sdram_ack", 64'(sd_if.sdram_ack), 64'd0);
    chk("t6_rst_cmd_valid", 64'(sd_if.sdram_cmd_valid), 64'd0);
    chk("t6_rst_cmd_ready", 64'(port_cmd_ready), 64'd0);
    chk("t6_rst_owner", 64'(owner), 64'd0);
    chk("t6_rst_cnt", 64'(u_dut.cnt_q), 64'd0);
    chk("t6_rst_state", 64'(u_dut.state_q), 64'(ARB_IDLE));
    port_ack = '0;
    sd_if.sdram_resp_valid = 1'b0;
    sd_if.sdram_resp_last  = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_first_ready", 64'(port_cmd_ready), 64'b0001);
    sb_q.push_back(0);
    wait_grant(1, "t6_regrant");
    port_cmd_valid = '0;
    port_ack = 4'b0001;
    step();
    port_ack = '0;

    // Ports 1..3 continuously requesting, six transactions.
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    rr_exp = '{1, 2, 3, 1, 2, 3};
`else
    rr_exp = '{1, 1, 1, 1, 1, 1};
`endif
    for (int t = 0; t < 6; t++) sb_q.push_back(rr_exp[t]);
    port_cmd_valid = 4'b1110;
    for (int t = 0; t < 6; t++) begin
      wait_grant(3, "t7_rr_grant");
      port_ack = 4'b0001 << owner;
      step();
      port_ack = '0;
    end
    port_cmd_valid = '0;
    chk("t7_sb_empty", 64'(sb_q.size()), 64'd0);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdram_mport_arbiter.md
SDRAM_MPORT_ARBITER -- requirements
Module: sdram_mport_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesting ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 24, SDRAM x16 word address width.
REQ-003 SHALL have parameter DATA_W, default 16, SDRAM data width; wmask width DATA_W/8.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, cycles sdram_rdy is ignored after grant (0..7).
REQ-005 SHALL have parameter PRIO_PORT, default 0, index of the always-first port (video).
REQ-006 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have downstream ports: sdram_cmd_valid/rd/wr/burst/ack out 1; sdram_addr_x16 out ADDR_W; sdram_wdata out DATA_W; sdram_wmask out DATA_W/8; sdram_cmd_ready/rdy/resp_valid/resp_last in 1; sdram_rdata in DATA_W.
REQ-008 SHALL have per-port packed-array ports: port_cmd_valid/rd/wr/burst/ack in NUM_PORTS; port_addr_x16 in NUM_PORTS*ADDR_W; port_wdata in NUM_PORTS*DATA_W; port_wmask in NUM_PORTS*DATA_W/8; port_cmd_ready/rdy/resp_valid/resp_last out NUM_PORTS; port_rdata out DATA_W (broadcast).
REQ-009 SHALL have status output owner_o  out  $clog2(NUM_PORTS)  current owner; busy_o  out  1  state is BUSY.

Function
REQ-010 SHALL implement states IDLE and BUSY; one transaction owned at a time.
REQ-011 In IDLE, winner SHALL be PRIO_PORT if its port_cmd_valid is high, else picked among other valid ports per REQ-024/025.
REQ-012 sdram_cmd_valid SHALL equal IDLE && any port_cmd_valid; deasserted in BUSY.
REQ-013 port_cmd_ready[i] SHALL be combinational: rst_ni && IDLE && sdram_cmd_ready && i==winner; all others 0.
REQ-014 In IDLE with a winner, winner's rd/wr/addr/wdata/wmask/burst SHALL drive downstream in the same cycle.
REQ-015 On port_cmd_valid[w]&&port_cmd_ready[w], SHALL move to BUSY next edge, owner<=w, wait counter<=WAIT_CYCLES.
REQ-016 In BUSY, owner's command fields and port_ack SHALL drive downstream; port_rdy[owner]=(counter==0)&&sdram_rdy; port_resp_valid/resp_last[owner] mirror downstream; all non-owner rdy/resp outputs 0.
REQ-017 Wait counter SHALL decrement by 1 per cycle while nonzero, saturating at 0.
REQ-018 In BUSY, port_ack[owner] high SHALL return to IDLE next edge; acks from non-owners ignored.
REQ-019 No new grant SHALL occur in the cycle port_ack is sampled; earliest next grant is the following cycle.
REQ-020 In IDLE, downstream rd, wr, ack SHALL be 0; addr, wdata, wmask, burst 0 (no X).
REQ-021 Same-cycle valid on PRIO_PORT and others SHALL grant PRIO_PORT; others keep valid with ready low.
REQ-022 port_cmd_valid deasserted before accept SHALL not cause a grant; no request is latched.
REQ-023 sdram_rdata SHALL pass combinationally to port_rdata.

Configuration
REQ-024 With SDRAM_ARB_ROUND_ROBIN_EN defined, non-priority ports SHALL be picked round-robin from pointer rr_ptr; rr_ptr<=winner+1 (mod NUM_PORTS, skipping PRIO_PORT) on each non-priority grant.
REQ-025 Without SDRAM_ARB_ROUND_ROBIN_EN, non-priority ports SHALL be picked by lowest index; rr_ptr not instantiated.

Reset
REQ-026 rst_ni low SHALL asynchronously force IDLE, owner 0, wait counter 0, rr_ptr to lowest non-priority index.
REQ-027 While in reset, all port_cmd_ready, port_rdy, port_resp_valid, port_resp_last, sdram_cmd_valid, sdram_rd, sdram_wr, sdram_ack, busy_o SHALL be 0.
REQ-028 Reset mid-BUSY SHALL abandon the transaction with no ack emitted; first grant possible in the first cycle after rst_ni rises.

Structure
REQ-029 Package sdram_arb_pkg SHALL hold the state enum (ARB_IDLE, ARB_BUSY) and default width constants.
REQ-030 Round-robin selection SHALL live in sub-module sdram_arb_rr_picker (request vector, pointer in; one-hot grant, index out).

Verification
REQ-031 Single CPU write: port1 valid, wr=1, addr=24'h000100, wdata=16'hBEEF -> ready1 same cycle, downstream addr 24'h000100, busy_o next edge, port_rdy[1] not before 2 cycles, ack1 -> IDLE next edge.
REQ-032 Priority: ports 0 and 2 valid same cycle -> port 0 granted; port 2 granted the first IDLE cycle after ack0.
REQ-033 Round-robin (macro on): ports 1,2,3 continuously valid, 6 transactions -> grant order 1,2,3,1,2,3; macro off -> 1,1,1,1,1,1.
REQ-034 Non-owner isolation: owner 2 in BUSY, sdram_resp_valid pulsed and ack1 asserted -> only port_resp_valid[2] high; state stays BUSY.
REQ-035 Reset mid-burst: owner 0 with WAIT_CYCLES=3, rst_ni low 1 cycle at counter=2 -> all outputs 0 immediately, IDLE, counter 0.
REQ-036 Back-pressure: sdram_cmd_ready=0 with port 3 valid for 5 cycles -> no ready, no state change; ready3 in the cycle sdram_cmd_ready rises.
